// File: rtl/tlc_pkg.sv
// Shared types for the two-road traffic-light controller: phase codes and lamp patterns.
package tlc_pkg;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    RED1  = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    RED2  = 3'd5,
    FLASH = 3'd6
  } phase_t;

  // Lamp order is {R,Y,G}
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;
  localparam logic [2:0] L_OFF = 3'b000;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the intersection controller (master) and the signal heads / inputs (slave).
interface tlc_if;
  logic       night_i;
  logic       ped_req_i;
  logic [2:0] leds_a;
  logic [2:0] leds_b;
  logic       ped_walk_o;
  logic [2:0] phase_o;
  logic       tick_o;

  modport master (
    input  night_i, ped_req_i,
    output leds_a, leds_b, ped_walk_o, phase_o, tick_o
  );

  modport slave (
    output night_i, ped_req_i,
    input  leds_a, leds_b, ped_walk_o, phase_o, tick_o
  );
endinterface

// File: rtl/traffic_light_ctrl_prescaler.sv
// Seconds prescaler: counts 0..CLK_DIV-1 and strobes tick on the last count.
module tlc_prescaler #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int unsigned W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] MAX = W'(CLK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt <= '0;
    else if (cnt == MAX) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end

  // Gated by reset so the strobe is quiet while held, even when CLK_DIV=1.
  assign tick = rst_n && (cnt == MAX);
endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller: six timed phases plus night flashing-yellow.
// Optional pedestrian request (shortens road A green, lights walk during B green): define TLC_PED_EN.
module traffic_light_ctrl
  import tlc_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 50_000_000,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_AGRN   = 5,
  parameter int unsigned T_AYEL   = 3,
  parameter int unsigned T_RED1   = 3,
  parameter int unsigned T_BGRN   = 10,
  parameter int unsigned T_BYEL   = 3,
  parameter int unsigned T_RED2   = 3,
  parameter int unsigned T_MINGRN = 2
) (
  input logic  clk,
  input logic  rst_n,
  tlc_if.master bus
);
  localparam logic [CNT_W-1:0] LAST_AGRN = CNT_W'(T_AGRN - 1);
  localparam logic [CNT_W-1:0] LAST_AYEL = CNT_W'(T_AYEL - 1);
  localparam logic [CNT_W-1:0] LAST_RED1 = CNT_W'(T_RED1 - 1);
  localparam logic [CNT_W-1:0] LAST_BGRN = CNT_W'(T_BGRN - 1);
  localparam logic [CNT_W-1:0] LAST_BYEL = CNT_W'(T_BYEL - 1);
  localparam logic [CNT_W-1:0] LAST_RED2 = CNT_W'(T_RED2 - 1);
  localparam logic [CNT_W-1:0] LAST_MIN  = CNT_W'(T_MINGRN - 1);

  logic             tick;
  phase_t           phase, phase_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic             flash, flash_nx;
  logic             ped_cut;

  tlc_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= RED2;
      timer <= '0;
      flash <= 1'b0;
    end else begin
      phase <= phase_nx;
      timer <= timer_nx;
      flash <= flash_nx;
    end
  end

  always_comb begin
    phase_nx = phase;
    timer_nx = timer;
    flash_nx = flash;
    if (tick) begin
      timer_nx = timer + 1'b1;
      case (phase)
        A_GRN: if (timer == LAST_AGRN || ped_cut) phase_nx = A_YEL;
        A_YEL: if (timer == LAST_AYEL) phase_nx = RED1;
        RED1:  if (timer == LAST_RED1) phase_nx = bus.night_i ? FLASH : B_GRN;
        B_GRN: if (timer == LAST_BGRN) phase_nx = B_YEL;
        B_YEL: if (timer == LAST_BYEL) phase_nx = RED2;
        RED2:  if (timer == LAST_RED2) phase_nx = bus.night_i ? FLASH : A_GRN;
        FLASH: begin
          // Timer is idle in FLASH; only the flash bit advances.
          timer_nx = timer;
          if (!bus.night_i) phase_nx = RED2;
          else              flash_nx = ~flash;
        end
        default: phase_nx = RED2;
      endcase
      if (phase_nx != phase) begin
        timer_nx = '0;
        flash_nx = 1'b0;
      end
    end
  end

`ifdef TLC_PED_EN
  logic ped_pend, ped_srv, ped_prev;
  logic b_entry, b_exit;

  assign b_entry = (phase_nx == B_GRN) && (phase != B_GRN);
  assign b_exit  = (phase == B_GRN) && (phase_nx != B_GRN);
  assign ped_cut = ped_pend && (timer >= LAST_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ped_prev <= 1'b0;
      ped_pend <= 1'b0;
      ped_srv  <= 1'b0;
    end else begin
      ped_prev <= bus.ped_req_i;
      if (b_entry)     ped_srv <= ped_pend;
      else if (b_exit) ped_srv <= 1'b0;
      // A fresh press in the clearing cycle keeps the request pending.
      if (bus.ped_req_i && !ped_prev) ped_pend <= 1'b1;
      else if (b_entry)               ped_pend <= 1'b0;
    end
  end

  assign bus.ped_walk_o = ped_srv && (phase == B_GRN);
`else
  logic unused_ped;
  assign unused_ped     = bus.ped_req_i;
  assign ped_cut        = 1'b0;
  assign bus.ped_walk_o = 1'b0;
`endif

  always_comb begin
    bus.leds_a = L_RED;
    bus.leds_b = L_RED;
    case (phase)
      A_GRN: bus.leds_a = L_GRN;
      A_YEL: bus.leds_a = L_YEL;
      B_GRN: bus.leds_b = L_GRN;
      B_YEL: bus.leds_b = L_YEL;
      FLASH: begin
        bus.leds_a = flash ? L_YEL : L_OFF;
        bus.leds_b = flash ? L_YEL : L_OFF;
      end
      default: ;
    endcase
  end

  assign bus.phase_o = phase;
  assign bus.tick_o  = tick;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench: directed phase schedules queued per DUT, negedge monitors compare lamps, walk, tick and phase lengths.
module tb_traffic_light_ctrl;
  import tlc_pkg::*;

`ifdef TLC_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  typedef struct {
    logic [2:0] ph;
    logic [2:0] la;
    logic [2:0] lb;
    logic       walk;
    int         dur;   // clk cycles; 0 = length not checked
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, rst1_n;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t       q0[$];
  exp_t       q1[$];
  exp_t       cur[2];
  int         start[2], cyc[2];
  bit         armed[2];
  logic       fexp[2];
  logic [2:0] prev[2];
  int         tcnt;

  always #5 clk = ~clk;

  tlc_if bus0();
  tlc_if bus1();

  traffic_light_ctrl #(.CLK_DIV(4)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.master)
  );

  traffic_light_ctrl #(.CLK_DIV(1), .T_AYEL(1)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1.master)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic void push(input int d, input logic [2:0] ph, input logic [2:0] la,
                               input logic [2:0] lb, input logic w, input int dur);
    exp_t e;
    e.ph = ph; e.la = la; e.lb = lb; e.walk = w; e.dur = dur;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Reference model of the CLK_DIV=4 prescaler
  always @(posedge clk) begin
    if (!rst_n) tcnt <= 0;
    else        tcnt <= (tcnt + 1) % 4;
  end

  task automatic mon(input int d, input logic rst, input logic [2:0] ph, input logic [2:0] la,
                     input logic [2:0] lb, input logic walk, input logic tick, input logic tick_exp);
    logic [2:0] xl;
    int qs;
    if (!rst) begin
      armed[d] = 1'b0;
      return;
    end
    cyc[d]++;
    if (!armed[d] || ph != prev[d]) begin
      if (armed[d] && cur[d].dur != 0)
        chk($sformatf("dut%0d phase %0d length", d, prev[d]), cyc[d] - start[d], cur[d].dur);
      qs = (d == 0) ? q0.size() : q1.size();
      if (qs == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL dut%0d unexpected phase: actual=%0d required=none", d, ph);
        cur[d].ph = ph; cur[d].la = la; cur[d].lb = lb; cur[d].walk = walk; cur[d].dur = 0;
      end else begin
        cur[d] = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d phase", d), ph, cur[d].ph);
      end
      start[d] = cyc[d];
      prev[d]  = ph;
      armed[d] = 1'b1;
      fexp[d]  = 1'b0;
    end
    if (cur[d].ph == FLASH) begin
      xl = {1'b0, fexp[d], 1'b0};
      chk("flash leds_a", la, xl);
      chk("flash leds_b", lb, xl);
      if (tick_exp) fexp[d] = ~fexp[d];
    end else begin
      chk($sformatf("dut%0d leds_a", d), la, cur[d].la);
      chk($sformatf("dut%0d leds_b", d), lb, cur[d].lb);
    end
    chk($sformatf("dut%0d walk", d), walk, cur[d].walk);
    chk($sformatf("dut%0d tick", d), tick, tick_exp);
  endtask

  always @(negedge clk)
    mon(0, rst_n, bus0.phase_o, bus0.leds_a, bus0.leds_b, bus0.ped_walk_o, bus0.tick_o,
        rst_n && (tcnt == 3));

  always @(negedge clk)
    mon(1, rst1_n, bus1.phase_o, bus1.leds_a, bus1.leds_b, bus1.ped_walk_o, bus1.tick_o, rst1_n);

  task automatic wait_phase(input logic [2:0] ph);
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus0.phase_o != ph && n < 2000);
    chk("reach phase", bus0.phase_o, ph);
  endtask

  task automatic reset_checks(input int d);
    if (d == 0) begin
      chk("rst leds_a", bus0.leds_a, L_RED);
      chk("rst leds_b", bus0.leds_b, L_RED);
      chk("rst phase",  bus0.phase_o, RED2);
      chk("rst walk",   bus0.ped_walk_o, 1'b0);
      chk("rst tick",   bus0.tick_o, 1'b0);
    end else begin
      chk("rst1 phase", bus1.phase_o, RED2);
      chk("rst1 tick",  bus1.tick_o, 1'b0);
    end
  endtask

  task automatic wait_empty(input int d);
    int unsigned n = 0;
    while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("dut%0d schedule drained", d), (d == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    rst_n  = 1'b0;
    rst1_n = 1'b0;
    bus0.night_i = 1'b0; bus0.ped_req_i = 1'b0;
    bus1.night_i = 1'b0; bus1.ped_req_i = 1'b0;

    // dut0 schedule, CLK_DIV=4
    push(0, RED2,  L_RED, L_RED, 1'b0, 12);
    push(0, A_GRN, L_GRN, L_RED, 1'b0, PED ? 8 : 20);
    push(0, A_YEL, L_YEL, L_RED, 1'b0, 12);
    push(0, RED1,  L_RED, L_RED, 1'b0, 12);
    push(0, B_GRN, L_RED, L_GRN, PED,  40);
    push(0, B_YEL, L_RED, L_YEL, 1'b0, 12);
    push(0, RED2,  L_RED, L_RED, 1'b0, 12);
    push(0, A_GRN, L_GRN, L_RED, 1'b0, 20);
    push(0, A_YEL, L_YEL, L_RED, 1'b0, 12);
    push(0, RED1,  L_RED, L_RED, 1'b0, 12);
    push(0, B_GRN, L_RED, L_GRN, 1'b0, 40);
    push(0, B_YEL, L_RED, L_YEL, 1'b0, 12);
    push(0, RED2,  L_RED, L_RED, 1'b0, 12);
    push(0, FLASH, L_OFF, L_OFF, 1'b0, 24);
    push(0, RED2,  L_RED, L_RED, 1'b0, 12);
    push(0, A_GRN, L_GRN, L_RED, 1'b0, 20);
    push(0, A_YEL, L_YEL, L_RED, 1'b0, 12);
    push(0, RED1,  L_RED, L_RED, 1'b0, 12);
    push(0, B_GRN, L_RED, L_GRN, 1'b0, 0);
    push(0, RED2,  L_RED, L_RED, 1'b0, 12);
    push(0, A_GRN, L_GRN, L_RED, 1'b0, 20);
    push(0, A_YEL, L_YEL, L_RED, 1'b0, 12);
    push(0, RED1,  L_RED, L_RED, 1'b0, 12);
    push(0, B_GRN, L_RED, L_GRN, 1'b0, 40);
    push(0, B_YEL, L_RED, L_YEL, 1'b0, 0);

    // dut1 schedule, CLK_DIV=1, T_AYEL=1
    push(1, RED2,  L_RED, L_RED, 1'b0, 3);
    push(1, A_GRN, L_GRN, L_RED, 1'b0, 5);
    push(1, A_YEL, L_YEL, L_RED, 1'b0, 1);
    push(1, RED1,  L_RED, L_RED, 1'b0, 3);
    push(1, B_GRN, L_RED, L_GRN, 1'b0, 10);
    push(1, B_YEL, L_RED, L_YEL, 1'b0, 3);
    push(1, RED2,  L_RED, L_RED, 1'b0, 3);
    push(1, A_GRN, L_GRN, L_RED, 1'b0, 5);
    push(1, A_YEL, L_YEL, L_RED, 1'b0, 1);
    push(1, RED1,  L_RED, L_RED, 1'b0, 0);

    repeat (3) @(posedge clk);
    reset_checks(0);
    reset_checks(1);
    #1;
    rst_n  = 1'b1;
    rst1_n = 1'b1;

    fork
      begin
        wait_phase(A_GRN);
        bus0.ped_req_i = 1'b1;
        @(negedge clk);
        bus0.ped_req_i = 1'b0;
        wait_phase(B_YEL);
        wait_phase(A_GRN);
        wait_phase(B_GRN);
        bus0.night_i = 1'b1;
        wait_phase(FLASH);
        repeat (22) @(negedge clk);
        bus0.night_i = 1'b0;
        wait_phase(A_GRN);
        wait_phase(B_GRN);
        repeat (10) @(negedge clk);
        bus0.ped_req_i = 1'b1;
        @(negedge clk);
        bus0.ped_req_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        reset_checks(0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_empty(0);
        rst_n = 1'b0;
      end
      begin
        wait_empty(1);
        rst1_n = 1'b0;
      end
    join

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Parametrised two-road intersection controller and the next generation of the team's fixed six-phase traffic-light FSM. It adds a built-in seconds prescaler, per-phase durations set by parameters, a night flashing-yellow mode and an optional pedestrian request that shortens road A green. It sits directly behind the board clock and drives the two 3-lamp signal heads plus a walk lamp.

## Interface
- CLK_DIV, 50_000_000: clk cycles per timing tick (≥1)
- CNT_W, 8: phase-timer width; every duration < 2^CNT_W
- T_AGRN, 5: road A green, ticks
- T_AYEL, 3: road A yellow, ticks
- T_RED1, 3: all-red after A yellow, ticks
- T_BGRN, 10: road B green, ticks
- T_BYEL, 3: road B yellow, ticks
- T_RED2, 3: all-red after B yellow, ticks
- T_MINGRN, 2: minimum A green before a pedestrian cut-off, ticks (1 ≤ T_MINGRN ≤ T_AGRN)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- night_i  in  1  level; request flashing-yellow mode
- ped_req_i  in  1  pedestrian button, synchronous, any pulse width
- leds_a  out  3  road A lamps {R,Y,G}
- leds_b  out  3  road B lamps {R,Y,G}
- ped_walk_o  out  1  walk lamp
- phase_o  out  3  current phase code
- tick_o  out  1  one-cycle prescaler strobe

## Operation
- Phases: A_GRN, A_YEL, RED1, B_GRN, B_YEL, RED2, FLASH. Normal cycle: A_GRN→A_YEL→RED1→B_GRN→B_YEL→RED2→A_GRN.
- Lamps: A_GRN a=001 b=100. A_YEL a=010 b=100. RED1/RED2 a=100 b=100. B_GRN a=100 b=001. B_YEL a=100 b=010. FLASH a=b={0,flash,0}.
- Prescaler: 0..CLK_DIV-1, wraps. tick_o=1 in the cycle the count equals CLK_DIV-1. With CLK_DIV=1, tick_o is constantly 1.
- Phase timer: cleared on phase entry and incremented on each tick. The phase is left on the tick where timer==T_x-1. Each phase therefore lasts exactly T_x ticks.
- Night entry: night_i is sampled only at the exit tick of RED1 or RED2. If it is high, the next phase is FLASH instead of B_GRN/A_GRN.
- FLASH: the flash bit toggles every tick and is cleared on FLASH entry. FLASH is left on the first tick with night_i=0 and goes to RED2, which gives a full T_RED2 clearance before A_GRN.
- Pedestrian logic: see Configuration.
- Reset: phase=RED2, both timers 0, flash 0, ped latch 0. Outputs during reset: leds_a=100, leds_b=100, ped_walk_o=0, tick_o=0, phase_o=RED2 code.

## Timing
- All state changes occur on the rising clk edge of a tick cycle. Outputs are a combinational decode of registered state and appear in the same cycle as the phase change (0 latency).
- First A_GRN begins T_RED2 ticks after reset release. The first tick comes CLK_DIV cycles after release.
- night_i toggled mid-phase has no effect until the next RED1/RED2 exit tick or FLASH tick.
- Asserting rst_n low mid-phase returns everything to the reset values immediately, without waiting for a clock edge.

## Configuration
- TLC_PED_EN defined:
  - A rising edge of ped_req_i sets ped_pend.
  - In A_GRN with ped_pend=1 and timer≥T_MINGRN-1, A_GRN exits on that tick.
  - On B_GRN entry, ped_pend is transferred to ped_srv and then cleared. ped_walk_o=ped_srv during B_GRN. ped_srv is cleared on B_GRN exit.
  - A request that arrives in the same cycle as the clear stays pending (set wins).
  - Requests in FLASH are latched and served after night exit.
- TLC_PED_EN undefined: ped_req_i is ignored, ped_walk_o is tied to 0, and there is no ped logic.

## Structure
- Package tlc_pkg holds:
  - the phase enum: A_GRN=0, A_YEL=1, RED1=2, B_GRN=3, B_YEL=4, RED2=5, FLASH=6;
  - lamp constants: L_RED=3'b100, L_YEL=3'b010, L_GRN=3'b001, L_OFF=3'b000.
- One sub-module, tlc_prescaler (parameter CLK_DIV, output tick), is instantiated once. Phase FSM, timer and ped logic stay in the top module.

## Test plan
- CLK_DIV=4, defaults, night_i=0, no ped: phase sequence RED2(12 clk)→A_GRN(20)→A_YEL(12)→RED1(12)→B_GRN(40)→B_YEL(12)→RED2(12), lamps as specified, tick_o every 4th cycle.
- Ped, TLC_PED_EN defined: pulse ped_req_i 1 cycle at A_GRN tick 0 → A_GRN lasts 2 ticks. ped_walk_o=1 for all 10 B_GRN ticks, then 0.
- Same ped stimulus with the macro undefined → A_GRN lasts 5 ticks and ped_walk_o stays 0.
- night_i=1 raised during B_GRN → FLASH entered after RED2. leds_a=leds_b alternate 000/010 each tick. Drop night_i → RED2 for 3 ticks, then A_GRN.
- Assert rst_n low mid-B_GRN for 1 cycle → immediate leds 100/100, phase RED2, ped latch cleared. The sequence restarts as in scenario 1.
- CLK_DIV=1, T_AYEL=1: one-cycle phases behave correctly, and the timer never exceeds T_x-1.
